video_pattern_gen: RTL and testbench
====================================

# video_pattern_gen

Synthesizable parametrised video source producing the deserializer-side parallel video stream (frame valid, line valid, pixel data) from internal test patterns instead of a stored image. It sits in front of the CSI-2 packetizer in place of the SDI deserializer outputs. It is used for on-board bring-up and for regression without external video. Compared with a fixed 1080p30 stimulus it adds configurable geometry, vertical blanking with frame valid low, a selectable pattern mode, a bounded or free-running frame count, and abort on loss of enable.

## Interface

Parameters:
- DATA_W, 16: pixel word width; legal range 8..16.
- H_ACTIVE, 1920: active pixels per line.
- H_BLANK, 280: blank cycles per line.
- V_ACTIVE, 1080: active lines per frame.
- V_BLANK, 45: blank lines between frames.
- INIT_DELAY, 16000: cycles held idle after enable, covering D-PHY tinit; 0 is legal.
- FRAMES, 0: frames to emit; 0 means free-running.
- CHK_SHIFT, 5: log2 of the checkerboard square size.

Ports (one clock; reset is asynchronous and active-low):
- pix_clk_i  in  1  pixel clock.
- rst_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  level run request, typically PLL lock.
- mode_i  in  2  pattern select: 0 ramp, 1 colour bars, 2 checkerboard, 3 solid or PRBS.
- solid_i  in  DATA_W  solid pattern value.
- fv_o  out  1  frame valid, active high.
- lv_o  out  1  line valid, active high.
- data_o  out  DATA_W  pixel data.
- frame_cnt_o  out  16  frames completed since start.
- busy_o  out  1  high in INIT, ACTIVE or VBLANK.
- done_o  out  1  high in DONE.

## Operation

- The state machine has five states: IDLE, INIT, ACTIVE, VBLANK, DONE.
- Reset value of every output is 0, and the state resets to IDLE.
- IDLE → INIT when enable_i is sampled high.
  - frame_cnt_o clears to 0 on this transition.
  - The INIT counter loads INIT_DELAY.
- INIT counts down. At 0 it goes to ACTIVE; with INIT_DELAY=0 it goes straight to ACTIVE.
- ACTIVE: h_cnt runs 0..H_ACTIVE+H_BLANK-1 and v_cnt runs 0..V_ACTIVE-1.
  - fv_o is 1 throughout ACTIVE.
  - lv_o is 1 while h_cnt < H_ACTIVE.
  - data_o is 0 whenever lv_o is 0.
- When the last line's blank ends, frame_cnt_o increments; it saturates at 0xFFFF.
  - Then go to DONE if FRAMES≠0 and the new count equals FRAMES; the final VBLANK is not emitted.
  - Otherwise go to VBLANK.
- VBLANK lasts V_BLANK×(H_ACTIVE+H_BLANK) cycles with fv_o=lv_o=0, then returns to ACTIVE.
  - With V_BLANK=0, frames are back-to-back with fv_o held high.
- DONE holds all video outputs at 0 and done_o=1 until enable_i is low; then it goes to IDLE.
- enable_i low in INIT, ACTIVE or VBLANK aborts to IDLE on the next edge.
  - fv_o, lv_o and data_o become 0 on that same edge.
  - frame_cnt_o holds its value.
- mode_i and solid_i are captured on entry to ACTIVE and held for the whole frame. Changes mid-frame take effect at the next frame.
- Pattern rules (x = h_cnt, y = v_cnt, all results truncated to DATA_W):
  - Ramp: data = x.
  - Bars: bar index b = 0..7, advanced by a BAR_W = H_ACTIVE/8 sub-counter, no divider. The last bar absorbs the remainder. data = b × ((2^DATA_W−1)/7).
  - Checkerboard: data is all-ones when ((x>>CHK_SHIFT) ^ (y>>CHK_SHIFT)) bit 0 is 1, otherwise 0.
  - Mode 3: see Configuration.

## Timing

- All outputs are registered. There is no combinational path from inputs to outputs.
- If enable_i is first sampled high at edge N, the first pixel (fv_o=lv_o=1) is presented after edge N+INIT_DELAY+1.
- Line period is H_ACTIVE+H_BLANK cycles.
- Frame period is (V_ACTIVE+V_BLANK)×(H_ACTIVE+H_BLANK) cycles.
- fv_o rises on the same edge as the first lv_o of a frame.
- fv_o falls one cycle after the final H_BLANK cycle of line V_ACTIVE−1.
- frame_cnt_o updates on the same edge that fv_o falls.
- done_o rises on the same edge that fv_o falls for the last frame.

## Configuration

- VIDEO_PATTERN_GEN_PRBS_EN defined: mode 3 outputs a 16-bit LFSR.
  - Polynomial x^16+x^14+x^13+x^11+1.
  - Seeded to 0xACE1 at each frame start and advanced once per active pixel.
  - data_o takes the low DATA_W bits.
- Undefined: mode 3 outputs solid_i and no LFSR logic is built.

## Test plan

Bench parameters: H_ACTIVE=16, H_BLANK=4, V_ACTIVE=4, V_BLANK=2, INIT_DELAY=10, FRAMES=2, DATA_W=16.

- Reset, then enable_i high at edge N, mode 0 → first lv_o after edge N+11.
  - Each line has 16 active cycles with data 0..15, then 4 cycles at 0.
  - fv_o stays high for 80 cycles, then low for 40.
  - done_o rises after the second frame; frame_cnt_o=2.
- Mode 1 → 8 bars of 2 pixels each, values 0, 9362, …, 65534; identical on every line.
- Mode 2 with CHK_SHIFT=1 → line 0 reads 0,0,FFFF,FFFF,…; line 2 is inverted relative to line 0.
- enable_i dropped in line 2 of frame 0 → all video outputs 0 on the next edge; state is IDLE; frame_cnt_o=0.
  - Re-enabling restarts with a full INIT_DELAY.
- mode_i changed from 0 to 2 mid-frame → current frame stays ramp; next frame is checkerboard.
- Mode 3 with PRBS_EN → first pixels 0xACE1 then LFSR successors, identical in both frames.
  - Without the macro and solid_i=0x1234 → every active pixel reads 0x1234.

Source files
------------

// File: rtl/video_pattern_gen.sv
// Parametrised test-pattern video source (fv/lv/data) standing in for the SDI deserializer.
// Optional build macro VIDEO_PATTERN_GEN_PRBS_EN: mode 3 emits a 16-bit PRBS instead of solid_i.
module video_pattern_gen #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned H_ACTIVE   = 1920,
    parameter int unsigned H_BLANK    = 280,
    parameter int unsigned V_ACTIVE   = 1080,
    parameter int unsigned V_BLANK    = 45,
    parameter int unsigned INIT_DELAY = 16000,
    parameter int unsigned FRAMES     = 0,
    parameter int unsigned CHK_SHIFT  = 5
) (
    input  logic              pix_clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] solid_i,
    output logic              fv_o,
    output logic              lv_o,
    output logic [DATA_W-1:0] data_o,
    output logic [15:0]       frame_cnt_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_BLANK;
    localparam int unsigned VB_TOTAL = V_BLANK * H_TOTAL;
    localparam int unsigned H_W      = $clog2(H_TOTAL + 2);
    localparam int unsigned V_W      = $clog2(V_ACTIVE + 2);
    localparam int unsigned I_W      = $clog2(INIT_DELAY + 2);
    localparam int unsigned VB_W     = $clog2(VB_TOTAL + 2);
    localparam int unsigned BAR_W    = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
    localparam int unsigned BS_W     = $clog2(BAR_W + 2);
    localparam int unsigned BAR_STEP = ((2 ** DATA_W) - 1) / 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ACTIVE,
        S_VBLANK,
        S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [I_W-1:0]    r_init_cnt, w_init_nxt;
    logic [VB_W-1:0]   r_vb_cnt, w_vb_nxt;
    logic [H_W-1:0]    r_h, w_h_nxt;
    logic [V_W-1:0]    r_v, w_v_nxt;
    logic [15:0]       r_frame_cnt, w_frame_nxt, w_frame_inc;
    logic [1:0]        r_mode, w_mode_nxt;
    logic [2:0]        r_bar, w_bar_nxt;
    logic [BS_W-1:0]   r_bar_sub, w_sub_nxt;
    logic              w_start;
    logic              w_pix;
    logic              w_lv_nxt;
    logic              w_chk;
    logic [DATA_W-1:0] w_mode3;
    logic [DATA_W-1:0] w_pat;
    logic              r_fv, r_lv, r_busy, r_done;
    logic [DATA_W-1:0] r_data;

    // Sequencing: w_pix marks that the next cycle presents a position inside ACTIVE.
    always_comb begin
        w_state_nxt = r_state;
        w_init_nxt  = r_init_cnt;
        w_vb_nxt    = r_vb_cnt;
        w_h_nxt     = r_h;
        w_v_nxt     = r_v;
        w_frame_nxt = r_frame_cnt;
        w_mode_nxt  = r_mode;
        w_start     = 1'b0;
        w_pix       = 1'b0;
        w_frame_inc = (r_frame_cnt == 16'hFFFF) ? r_frame_cnt : r_frame_cnt + 16'd1;
        case (r_state)
            S_IDLE: begin
                if (enable_i) begin
                    w_state_nxt = S_INIT;
                    w_init_nxt  = I_W'(INIT_DELAY);
                    w_frame_nxt = 16'd0;
                end
            end
            S_INIT: begin
                if (!enable_i)               w_state_nxt = S_IDLE;
                else if (r_init_cnt == '0)   w_start     = 1'b1;
                else                         w_init_nxt  = r_init_cnt - I_W'(1);
            end
            S_ACTIVE: begin
                if (!enable_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_h == H_W'(H_TOTAL - 1)) begin
                    w_h_nxt = '0;
                    if (r_v == V_W'(V_ACTIVE - 1)) begin
                        w_frame_nxt = w_frame_inc;
                        if ((FRAMES != 0) && (32'(w_frame_inc) == FRAMES)) begin
                            w_state_nxt = S_DONE;
                        end else if (V_BLANK == 0) begin
                            w_start = 1'b1;
                        end else begin
                            w_state_nxt = S_VBLANK;
                            w_vb_nxt    = VB_W'(VB_TOTAL - 1);
                        end
                    end else begin
                        w_v_nxt = r_v + V_W'(1);
                        w_pix   = 1'b1;
                    end
                end else begin
                    w_h_nxt = r_h + H_W'(1);
                    w_pix   = 1'b1;
                end
            end
            S_VBLANK: begin
                if (!enable_i)             w_state_nxt = S_IDLE;
                else if (r_vb_cnt == '0)   w_start     = 1'b1;
                else                       w_vb_nxt    = r_vb_cnt - VB_W'(1);
            end
            S_DONE: begin
                if (!enable_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_start) begin
            w_state_nxt = S_ACTIVE;
            w_h_nxt     = '0;
            w_v_nxt     = '0;
            w_mode_nxt  = mode_i;
            w_pix       = 1'b1;
        end
    end

    assign w_lv_nxt = w_pix && (w_h_nxt < H_W'(H_ACTIVE));

    // Bar index advances by a sub-counter; bar 7 holds to absorb the H_ACTIVE/8 remainder.
    always_comb begin
        w_bar_nxt = r_bar;
        w_sub_nxt = r_bar_sub;
        if (w_pix) begin
            if (w_h_nxt == '0) begin
                w_bar_nxt = 3'd0;
                w_sub_nxt = '0;
            end else if (r_bar != 3'd7) begin
                if ((32'(r_bar_sub) + 32'd1) == BAR_W) begin
                    w_bar_nxt = r_bar + 3'd1;
                    w_sub_nxt = '0;
                end else begin
                    w_sub_nxt = r_bar_sub + BS_W'(1);
                end
            end
        end
    end

`ifdef VIDEO_PATTERN_GEN_PRBS_EN
    localparam logic [15:0] PRBS_SEED = 16'hACE1;

    logic [15:0] r_lfsr, w_lfsr_nxt, w_lfsr_out;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // r_lfsr holds the value for the next active pixel; reseeded at every frame start.
    always_comb begin
        w_lfsr_nxt = r_lfsr;
        w_lfsr_out = r_lfsr;
        if (w_start) begin
            w_lfsr_out = PRBS_SEED;
            w_lfsr_nxt = lfsr_step(PRBS_SEED);
        end else if (w_lv_nxt) begin
            w_lfsr_nxt = lfsr_step(r_lfsr);
        end
    end

    always_ff @(posedge pix_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_lfsr <= '0;
        else          r_lfsr <= w_lfsr_nxt;
    end

    assign w_mode3 = DATA_W'(w_lfsr_out);
`else
    logic [DATA_W-1:0] r_solid;

    always_ff @(posedge pix_clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     r_solid <= '0;
        else if (w_start) r_solid <= solid_i;
    end

    assign w_mode3 = w_start ? solid_i : r_solid;
`endif

    assign w_chk = (((32'(w_h_nxt) >> CHK_SHIFT) ^ (32'(w_v_nxt) >> CHK_SHIFT)) & 32'd1) != 32'd0;

    always_comb begin
        w_pat = '0;
        case (w_mode_nxt)
            2'd0:    w_pat = DATA_W'(w_h_nxt);
            2'd1:    w_pat = DATA_W'(32'(w_bar_nxt) * BAR_STEP);
            2'd2:    w_pat = w_chk ? '1 : '0;
            default: w_pat = w_mode3;
        endcase
    end

    always_ff @(posedge pix_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_init_cnt  <= '0;
            r_vb_cnt    <= '0;
            r_h         <= '0;
            r_v         <= '0;
            r_frame_cnt <= '0;
            r_mode      <= '0;
            r_bar       <= '0;
            r_bar_sub   <= '0;
            r_fv        <= 1'b0;
            r_lv        <= 1'b0;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_cnt  <= w_init_nxt;
            r_vb_cnt    <= w_vb_nxt;
            r_h         <= w_h_nxt;
            r_v         <= w_v_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_mode      <= w_mode_nxt;
            r_bar       <= w_bar_nxt;
            r_bar_sub   <= w_sub_nxt;
            r_fv        <= (w_state_nxt == S_ACTIVE);
            r_lv        <= w_lv_nxt;
            r_data      <= w_lv_nxt ? w_pat : '0;
            r_busy      <= (w_state_nxt == S_INIT) || (w_state_nxt == S_ACTIVE) ||
                           (w_state_nxt == S_VBLANK);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign fv_o        = r_fv;
    assign lv_o        = r_lv;
    assign data_o      = r_data;
    assign frame_cnt_o = r_frame_cnt;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen: timeline model of the video stream plus directed spot checks.
// Honours VIDEO_PATTERN_GEN_PRBS_EN for the mode 3 expectations.
module tb_video_pattern_gen;

    localparam int DATA_W     = 16;
    localparam int H_ACTIVE   = 16;
    localparam int H_BLANK    = 4;
    localparam int V_ACTIVE   = 4;
    localparam int V_BLANK    = 2;
    localparam int INIT_DELAY = 10;
    localparam int FRAMES     = 2;
    localparam int CHK_SHIFT  = 1;
    localparam int HT         = H_ACTIVE + H_BLANK;
    localparam int FP         = (V_ACTIVE + V_BLANK) * HT;
    localparam int BAR_W      = H_ACTIVE / 8;

    logic              pix_clk_i = 1'b0;
    logic              rst_n_i   = 1'b1;
    logic              enable_i  = 1'b0;
    logic [1:0]        mode_i    = 2'd0;
    logic [DATA_W-1:0] solid_i   = '0;
    logic              fv_o, lv_o, busy_o, done_o;
    logic [DATA_W-1:0] data_o;
    logic [15:0]       frame_cnt_o;

    int checks = 0;
    int errors = 0;

    video_pattern_gen #(
        .DATA_W(DATA_W), .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
        .V_BLANK(V_BLANK), .INIT_DELAY(INIT_DELAY), .FRAMES(FRAMES), .CHK_SHIFT(CHK_SHIFT)
    ) dut (
        .pix_clk_i(pix_clk_i), .rst_n_i(rst_n_i), .enable_i(enable_i), .mode_i(mode_i),
        .solid_i(solid_i), .fv_o(fv_o), .lv_o(lv_o), .data_o(data_o),
        .frame_cnt_o(frame_cnt_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 pix_clk_i = ~pix_clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef VIDEO_PATTERN_GEN_PRBS_EN
    // n-th PRBS word of a frame: seed 0xACE1 stepped n times by x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] prbs_at(input int n);
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < n; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        return s;
    endfunction
`endif

    function automatic logic [15:0] pat(input int md, input int h, input int ln, input logic [15:0] sd);
        int b;
        logic [15:0] v;
        v = 16'd0;
        case (md)
            0: v = 16'(h);
            1: begin
                b = h / BAR_W;
                if (b > 7) b = 7;
                v = 16'(b * (65535 / 7));
            end
            2: v = ((((h >> CHK_SHIFT) ^ (ln >> CHK_SHIFT)) & 1) != 0) ? 16'hFFFF : 16'h0000;
            default: begin
`ifdef VIDEO_PATTERN_GEN_PRBS_EN
                v = prbs_at(ln * H_ACTIVE + h);
`else
                v = sd;
`endif
            end
        endcase
        return v;
    endfunction

    // Model: timeline position since the enable edge gives init / frame / line / pixel.
    int          m_phase  = 0;
    int          m_t      = 0;
    int          m_fcnt   = 0;
    int          m_fmode  = 0;
    logic [15:0] m_fsolid = '0;

    always @(posedge pix_clk_i) begin
        int k, f, r, ln, h;
        logic e_fv, e_lv, e_busy, e_done;
        logic [15:0] e_data;
        e_fv = 1'b0; e_lv = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_data = 16'd0;
        if (!rst_n_i) begin
            m_phase = 0;
            m_fcnt  = 0;
        end else begin
            case (m_phase)
                0: if (enable_i) begin m_phase = 1; m_t = 0; m_fcnt = 0; end
                1: if (!enable_i) m_phase = 0; else m_t++;
                default: if (!enable_i) m_phase = 0;
            endcase
            if (m_phase == 1) begin
                e_busy = 1'b1;
                if (m_t > INIT_DELAY) begin
                    k  = m_t - INIT_DELAY - 1;
                    f  = k / FP;
                    r  = k % FP;
                    ln = r / HT;
                    h  = r % HT;
                    if (k >= (FRAMES - 1) * FP + V_ACTIVE * HT) begin
                        m_phase = 2;
                        m_fcnt  = FRAMES;
                    end else if (ln < V_ACTIVE) begin
                        if (r == 0) begin m_fmode = int'(mode_i); m_fsolid = solid_i; end
                        e_fv   = 1'b1;
                        e_lv   = (h < H_ACTIVE);
                        m_fcnt = f;
                        if (e_lv) e_data = pat(m_fmode, h, ln, m_fsolid);
                    end else begin
                        m_fcnt = f + 1;
                    end
                end
            end
            if (m_phase == 2) begin
                e_busy = 1'b0;
                e_done = 1'b1;
            end
        end
        #1;
        chk("model_fv",   32'(fv_o),        32'(e_fv));
        chk("model_lv",   32'(lv_o),        32'(e_lv));
        chk("model_data", 32'(data_o),      32'(e_data));
        chk("model_fcnt", 32'(frame_cnt_o), 32'(m_fcnt));
        chk("model_busy", 32'(busy_o),      32'(e_busy));
        chk("model_done", 32'(done_o),      32'(e_done));
    end

    task automatic start(input logic [1:0] md);
        @(negedge pix_clk_i);
        mode_i   = md;
        enable_i = 1'b1;
        @(posedge pix_clk_i);
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge pix_clk_i);
        #1;
    endtask

    task automatic stop();
        @(negedge pix_clk_i);
        enable_i = 1'b0;
        repeat (2) @(posedge pix_clk_i);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < 400) begin
            @(posedge pix_clk_i);
            #1;
            n++;
        end
        chk(name, 32'(done_o), 32'd1);
    endtask

    task automatic first_lv(input string name);
        int i;
        i = 0;
        #1;
        while (lv_o !== 1'b1 && i < 100) begin
            @(posedge pix_clk_i);
            #1;
            i++;
        end
        chk(name, 32'(i), 32'd11);
    endtask

    initial begin
        int n;
        #2 rst_n_i = 1'b0;
        adv(3);
        chk("rst_fv",   32'(fv_o),        32'd0);
        chk("rst_lv",   32'(lv_o),        32'd0);
        chk("rst_data", 32'(data_o),      32'd0);
        chk("rst_fcnt", 32'(frame_cnt_o), 32'd0);
        chk("rst_busy", 32'(busy_o),      32'd0);
        chk("rst_done", 32'(done_o),      32'd0);
        @(negedge pix_clk_i);
        rst_n_i = 1'b1;
        adv(2);

        // Ramp: latency, frame timing, bounded frame count.
        start(2'd0);
        first_lv("first_lv_latency");
        n = 0;
        while (fv_o === 1'b1 && n < 500) begin n++; adv(1); end
        chk("fv_high_len", 32'(n), 32'd80);
        n = 0;
        while (fv_o === 1'b0 && n < 500) begin n++; adv(1); end
        chk("fv_low_len", 32'(n), 32'd40);
        wait_done("ramp_done");
        chk("ramp_fcnt", 32'(frame_cnt_o), 32'd2);
        stop();
        chk("idle_after_done", 32'(done_o), 32'd0);

        // Colour bars.
        start(2'd1);
        adv(13); chk("bar_px2",    32'(data_o), 32'd9362);
        adv(2);  chk("bar_px4",    32'(data_o), 32'd18724);
        adv(10); chk("bar_px14",   32'(data_o), 32'd65534);
        adv(20); chk("bar_l1_px14", 32'(data_o), 32'd65534);
        wait_done("bars_done");
        stop();

        // Checkerboard with 2-pixel squares.
        start(2'd2);
        adv(11); chk("chk_l0_px0", 32'(data_o), 32'h0000);
        adv(2);  chk("chk_l0_px2", 32'(data_o), 32'hFFFF);
        adv(38); chk("chk_l2_px0", 32'(data_o), 32'hFFFF);
        adv(2);  chk("chk_l2_px2", 32'(data_o), 32'h0000);
        stop();

        // Abort in line 2 of frame 0, then restart with full init delay.
        start(2'd0);
        adv(56); chk("abort_pre_data", 32'(data_o), 32'd5);
        @(negedge pix_clk_i);
        enable_i = 1'b0;
        adv(1);
        chk("abort_fv",   32'(fv_o),        32'd0);
        chk("abort_lv",   32'(lv_o),        32'd0);
        chk("abort_data", 32'(data_o),      32'd0);
        chk("abort_busy", 32'(busy_o),      32'd0);
        chk("abort_fcnt", 32'(frame_cnt_o), 32'd0);
        adv(1);
        start(2'd0);
        first_lv("restart_latency");
        stop();

        // Mode change mid-frame applies from the next frame.
        start(2'd0);
        adv(41);
        @(negedge pix_clk_i);
        mode_i = 2'd2;
        adv(15); chk("modechg_cur_ramp", 32'(data_o), 32'd5);
        adv(77); chk("modechg_next_chk", 32'(data_o), 32'hFFFF);
        wait_done("modechg_done");
        stop();

        // Mode 3: PRBS when built in, otherwise solid_i.
        solid_i = 16'h1234;
        start(2'd3);
`ifdef VIDEO_PATTERN_GEN_PRBS_EN
        adv(11);  chk("m3_f0_px0", 32'(data_o), 32'hACE1);
        adv(1);   chk("m3_f0_px1", 32'(data_o), 32'h5670);
        adv(119); chk("m3_f1_px0", 32'(data_o), 32'hACE1);
`else
        adv(11);  chk("m3_f0_px0", 32'(data_o), 32'h1234);
        adv(1);   chk("m3_f0_px1", 32'(data_o), 32'h1234);
        adv(119); chk("m3_f1_px0", 32'(data_o), 32'h1234);
`endif
        wait_done("m3_done");
        stop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
